// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, ALU control codes,
// result-source codes, immediate formats and the immediate extender.
package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
    } ctrl_t;

    // Reassemble and sign-extend the scattered immediate bits of each format.
    function automatic logic [31:0] imm_extend(input logic [31:0] instr,
                                               input imm_src_e    src);
        logic [31:0] imm;
        case (src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bus between the decode stage and its neighbours: IF/ID inputs, writeback
// port, hazard-unit controls and the ID/EX register outputs.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            RegWriteW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;
    logic            StallD;
    logic            FlushE;
    logic [4:0]      Rs1D;
    logic [4:0]      Rs2D;
    logic            RegWriteE;
    logic [1:0]      ResultSrcE;
    logic            MemWriteE;
    logic            JumpE;
    logic            BranchE;
    logic [2:0]      ALUControlE;
    logic            ALUSrcE;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [XLEN-1:0] ImmExtE;
    logic [4:0]      Rs1E;
    logic [4:0]      Rs2E;
    logic [4:0]      RdE;

    modport master (
        output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, StallD, FlushE,
        input  Rs1D, Rs2D, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
               ALUControlE, ALUSrcE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
               Rs1E, Rs2E, RdE
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, StallD, FlushE,
        output Rs1D, Rs2D, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
               ALUControlE, ALUSrcE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
               Rs1E, Rs2E, RdE
    );
endinterface

// File: rtl/decode_stage_regfile.sv
// Architectural register file: x0 hardwired to zero, one synchronous write
// port from writeback, two asynchronous read ports.
// Optional macro DECODE_WB_BYPASS_EN forwards a same-cycle writeback value to
// the read ports; without it a read during write returns the old contents.
module register_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREGS];

    // Clear every register on reset, otherwise commit writeback (never x0).
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Asynchronous reads; x0 forced to zero regardless of array contents.
    always_comb begin
        rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
`ifdef DECODE_WB_BYPASS_EN
        if (we && (waddr != 5'd0) && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
        if (we && (waddr != 5'd0) && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, ALU decode, immediate extension,
// register-file read and the ID/EX pipeline register.
// Optional macro DECODE_WB_BYPASS_EN (handled in register_file) enables the
// same-cycle writeback-to-read bypass.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    decode_stage_if.slave bus
);

    typedef struct packed {
        ctrl_t           ctrl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } idex_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    ctrl_t           ctrl_p0;
    imm_src_e        imm_src_p0;
    logic            imm_en_p0;
    logic            use_funct_p0;
    logic [2:0]      alu_funct_p0;
    logic [2:0]      alu_fixed_p0;
    logic [XLEN-1:0] rd1_p0;
    logic [XLEN-1:0] rd2_p0;
    idex_t           idex_p0;
    idex_t           idex_p1;

    assign opcode   = bus.InstrD[6:0];
    assign funct3   = bus.InstrD[14:12];
    assign funct7b5 = bus.InstrD[30];

    assign bus.Rs1D = bus.InstrD[19:15];
    assign bus.Rs2D = bus.InstrD[24:20];

    // ---- Stage p0: decode of the instruction held in IF/ID ----

    register_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .CLK    (CLK),
        .RESET  (RESET),
        .we     (bus.RegWriteW),
        .waddr  (bus.RdW),
        .wdata  (bus.ResultW),
        .raddr1 (bus.InstrD[19:15]),
        .raddr2 (bus.InstrD[24:20]),
        .rdata1 (rd1_p0),
        .rdata2 (rd2_p0)
    );

    // Main decoder: per-opcode control bits; unknown opcodes become a NOP.
    always_comb begin
        ctrl_p0.reg_write  = 1'b0;
        ctrl_p0.result_src = RES_ALU;
        ctrl_p0.mem_write  = 1'b0;
        ctrl_p0.jump       = 1'b0;
        ctrl_p0.branch     = 1'b0;
        ctrl_p0.alu_src    = 1'b0;
        imm_src_p0         = IMM_I;
        imm_en_p0          = 1'b0;
        use_funct_p0       = 1'b0;
        alu_fixed_p0       = ALU_ADD;
        case (opcode)
            OP_LOAD: begin
                ctrl_p0.reg_write  = 1'b1;
                ctrl_p0.alu_src    = 1'b1;
                ctrl_p0.result_src = RES_MEM;
                imm_en_p0          = 1'b1;
            end
            OP_STORE: begin
                ctrl_p0.mem_write = 1'b1;
                ctrl_p0.alu_src   = 1'b1;
                imm_src_p0        = IMM_S;
                imm_en_p0         = 1'b1;
            end
            OP_RTYPE: begin
                ctrl_p0.reg_write = 1'b1;
                use_funct_p0      = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_p0.branch = 1'b1;
                alu_fixed_p0   = ALU_SUB;
                imm_src_p0     = IMM_B;
                imm_en_p0      = 1'b1;
            end
            OP_IALU: begin
                ctrl_p0.reg_write = 1'b1;
                ctrl_p0.alu_src   = 1'b1;
                use_funct_p0      = 1'b1;
                imm_en_p0         = 1'b1;
            end
            OP_JAL: begin
                ctrl_p0.reg_write  = 1'b1;
                ctrl_p0.jump       = 1'b1;
                ctrl_p0.result_src = RES_PC4;
                imm_src_p0         = IMM_J;
                imm_en_p0          = 1'b1;
            end
            default: begin
                ctrl_p0.reg_write = 1'b0;
            end
        endcase
        ctrl_p0.alu_control = use_funct_p0 ? alu_funct_p0 : alu_fixed_p0;
    end

    // ALU decoder: funct7[5] only selects sub for R-type, since for I-ALU
    // that bit is part of the immediate.
    always_comb begin
        case (funct3)
            3'b000:  alu_funct_p0 = ((opcode == OP_RTYPE) && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_funct_p0 = ALU_SLT;
            3'b110:  alu_funct_p0 = ALU_OR;
            3'b111:  alu_funct_p0 = ALU_AND;
            default: alu_funct_p0 = ALU_ADD;
        endcase
    end

    // Gather everything that crosses into ID/EX.
    always_comb begin
        idex_p0.ctrl     = ctrl_p0;
        idex_p0.rd1      = rd1_p0;
        idex_p0.rd2      = rd2_p0;
        idex_p0.pc       = bus.PCD;
        idex_p0.pc_plus4 = bus.PCPlus4D;
        idex_p0.imm      = imm_en_p0 ? imm_extend(bus.InstrD, imm_src_p0) : '0;
        idex_p0.rs1      = bus.InstrD[19:15];
        idex_p0.rs2      = bus.InstrD[24:20];
        idex_p0.rd       = bus.InstrD[11:7];
    end

    // ---- Stage p1: ID/EX register ----

    // Reset beats flush, flush beats stall; a flush leaves an all-zero bubble.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            idex_p1 <= '0;
        end else if (bus.FlushE) begin
            idex_p1 <= '0;
        end else if (!bus.StallD) begin
            idex_p1 <= idex_p0;
        end
    end

    assign bus.RegWriteE   = idex_p1.ctrl.reg_write;
    assign bus.ResultSrcE  = idex_p1.ctrl.result_src;
    assign bus.MemWriteE   = idex_p1.ctrl.mem_write;
    assign bus.JumpE       = idex_p1.ctrl.jump;
    assign bus.BranchE     = idex_p1.ctrl.branch;
    assign bus.ALUControlE = idex_p1.ctrl.alu_control;
    assign bus.ALUSrcE     = idex_p1.ctrl.alu_src;
    assign bus.RD1E        = idex_p1.rd1;
    assign bus.RD2E        = idex_p1.rd2;
    assign bus.PCE         = idex_p1.pc;
    assign bus.PCPlus4E    = idex_p1.pc_plus4;
    assign bus.ImmExtE     = idex_p1.imm;
    assign bus.Rs1E        = idex_p1.rs1;
    assign bus.Rs2E        = idex_p1.rs2;
    assign bus.RdE         = idex_p1.rd;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode stage of the 5-stage RV32I pipeline; sits directly downstream of the fetch stage.
- Consumes the IF/ID outputs `InstrD`, `PCD` and `PCPlus4D`, then produces:
  - control signals,
  - register-file reads,
  - the sign-extended immediate.
- Registers all of these into the ID/EX pipeline register.
- Owns the 32x32 register file, which is written by the writeback stage.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, number of architectural registers (x0 hardwired to zero).

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  synchronous, active-low reset.
- InstrD  in  32  instruction from IF/ID.
- PCD  in  32  PC of InstrD.
- PCPlus4D  in  32  PC+4 of InstrD.
- RegWriteW  in  1  writeback register-write enable.
- RdW  in  5  writeback destination register.
- ResultW  in  32  writeback data.
- StallD  in  1  hold the ID/EX register (hazard unit).
- FlushE  in  1  load a bubble into ID/EX (hazard unit / taken branch).
- Rs1D  out  5  InstrD[19:15], combinational, to hazard unit.
- Rs2D  out  5  InstrD[24:20], combinational, to hazard unit.
- RegWriteE  out  1  registered control.
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4.
- MemWriteE  out  1  registered control.
- JumpE  out  1  registered control.
- BranchE  out  1  registered control.
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- ALUSrcE  out  1  0 = RD2, 1 = immediate.
- RD1E  out  32  registered rs1 data.
- RD2E  out  32  registered rs2 data.
- PCE  out  32  registered PC.
- PCPlus4E  out  32  registered PC+4.
- ImmExtE  out  32  registered sign-extended immediate.
- Rs1E  out  5  registered rs1 index.
- Rs2E  out  5  registered rs2 index.
- RdE  out  5  registered rd index (InstrD[11:7]).

Behaviour:

Reset
- One clock and a synchronous, active-low reset. RESET==0 at a posedge is the only reset action.
- Reset clears every ID/EX output to 0 and all 32 registers to 0.
- Reset takes priority over StallD, FlushE and writes.

Register file
- Write on posedge when RegWriteW==1 and RdW!=0. Writes to x0 are ignored.
- Reads are combinational and asynchronous; x0 always reads 0.

Control decode (combinational, by InstrD[6:0])

| Instruction | Opcode | RegWrite | ImmSrc | ALUSrc | MemWrite | ResultSrc | Branch | ALUOp | Jump |
|---|---|---|---|---|---|---|---|---|---|
| lw | 0000011 | 1 | I | 1 | 0 | 01 | 0 | add | 0 |
| sw | 0100011 | 0 | S | 1 | 1 | xx→00 | 0 | add | 0 |
| R-type | 0110011 | 1 | – | 0 | 0 | 00 | 0 | funct | 0 |
| beq | 1100011 | 0 | B | 0 | 0 | 00 | 1 | sub | 0 |
| I-ALU | 0010011 | 1 | I | 1 | 0 | 00 | 0 | funct | 0 |
| jal | 1101111 | 1 | J | – | 0 | 10 | 0 | – | 1 |

- Any other opcode: all control outputs 0 (NOP). The immediate is don't-care but is driven as 0.

ALU decode
- funct3 000: sub only when R-type and funct7[5]==1; otherwise add.
- funct3 010 → slt; 110 → or; 111 → and.
- Other funct3 values → add.

Immediate generation
- I: {{20{I[31]}}, I[31:20]}
- S: {{20{I[31]}}, I[31:25], I[11:7]}
- B: {{19{I[31]}}, I[31], I[7], I[30:25], I[11:8], 1'b0}
- J: {{11{I[31]}}, I[31], I[19:12], I[20], I[30:21], 1'b0}

ID/EX register (posedge; latency 1 cycle from InstrD to *E)
- Priority: RESET low > FlushE > StallD > load.
- FlushE: clear all outputs to 0, producing a bubble (RegWriteE=0, MemWriteE=0).
- StallD: hold all outputs.
- StallD and FlushE together: flush wins.

Same-cycle write/read of the same register
- Behaviour depends on DECODE_WB_BYPASS_EN (see Optional Feature).

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: when RegWriteW==1, RdW!=0 and RdW equals Rs1D (or Rs2D), RD1 (or RD2) is taken from ResultW in the same cycle, so the read-during-write returns the new value.
- Undefined: reads return the old register contents. The hazard unit must then stall one extra cycle.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams,
  - ALUControl encodings,
  - ImmSrc enum (I, S, B, J),
  - ResultSrc encodings.
- Natural sub-module: register_file, containing the 32x32 array, the x0 rule and the optional bypass.
- Control decode, immediate extension and the ID/EX register stay in decode_stage.

Test Plan:
1. Reset clears state.
   - Stimulus: hold RESET=0 for 2 cycles with InstrD=0x00500093.
   - Required: all *E outputs 0; reading x1 afterwards returns 0.
2. addi decode.
   - Stimulus: InstrD=0x00500093 (addi x1,x0,5), PCD=0x10.
   - Required, next cycle:
     - ImmExtE=5, ALUSrcE=1, RegWriteE=1, ALUControlE=000;
     - RdE=1, RD1E=0, PCE=0x10, PCPlus4E=0x14.
3. Writeback then read.
   - Stimulus: RegWriteW=1, RdW=2, ResultW=0xDEADBEEF; next cycle InstrD=0x00210233 (add x4,x2,x2).
   - Required: RD1E=RD2E=0xDEADBEEF.
   - Stimulus: same cycle as the write with the macro defined.
   - Required: also 0xDEADBEEF.
   - Stimulus: same cycle as the write with the macro undefined.
   - Required: old value.
4. x0 is immutable.
   - Stimulus: RegWriteW=1, RdW=0, ResultW=0x1234; then read x0.
   - Required: RD1E=0.
5. Immediate sign extension.
   - Stimulus: sw x5,-4(x6) (0xFE532E23).
   - Required: ImmExtE=0xFFFFFFFC, MemWriteE=1, RegWriteE=0.
   - Stimulus: beq offset -8 (0xFE000CE3).
   - Required: ImmExtE=0xFFFFFFF8, BranchE=1, ALUControlE=001.
6. Stall and flush.
   - Stimulus: StallD=1 while InstrD changes.
   - Required: *E outputs hold.
   - Stimulus: StallD=1 and FlushE=1 together.
   - Required: all *E outputs become 0.
   - Stimulus: RESET=0 during a stall.
   - Required: all *E outputs become 0.
